// File: rtl/msrv32_pkg.sv
// Shared encodings for the MSRV32 machine-mode trap sequencer.
// MSRV32_WFI_EN adds the WAIT state and the WFI decode constants.
package msrv32_pkg;

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_OPERATING   = 3'd1,
        ST_TRAP_TAKEN  = 3'd2,
        ST_TRAP_RETURN = 3'd3
`ifdef MSRV32_WFI_EN
        , ST_WAIT      = 3'd4
`endif
    } state_e;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] CAUSE_MSI              = 4'd3;
    localparam logic [3:0] CAUSE_MTI              = 4'd7;
    localparam logic [3:0] CAUSE_MEI              = 4'd11;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_MEPC = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    localparam logic [4:0] OPC_SYSTEM  = 5'b11100;
    localparam logic [6:0] F7_ECALL    = 7'b0000000;
    localparam logic [6:0] F7_MRET     = 7'b0011000;
    localparam logic [4:0] RS2_ECALL   = 5'b00000;
    localparam logic [4:0] RS2_EBREAK  = 5'b00001;
    localparam logic [4:0] RS2_MRET    = 5'b00010;
`ifdef MSRV32_WFI_EN
    localparam logic [6:0] F7_WFI      = 7'b0001000;
    localparam logic [4:0] RS2_WFI     = 5'b00101;
`endif

    typedef struct packed {
        logic [1:0] pc_src;
        logic       flush;
        logic       set_epc;
        logic       set_cause;
        logic       mie_clear;
        logic       mie_set;
    } ctrl_outs_t;

    // Moore output table, evaluated on the next state so the outputs can be flopped.
    function automatic ctrl_outs_t state_outs(input state_e s);
        ctrl_outs_t o;
        o = '{pc_src: PC_SRC_BOOT, flush: 1'b1, set_epc: 1'b0, set_cause: 1'b0,
              mie_clear: 1'b0, mie_set: 1'b0};
        case (s)
            ST_OPERATING: begin
                o.pc_src = PC_SRC_NEXT;
                o.flush  = 1'b0;
            end
            ST_TRAP_TAKEN: begin
                o.pc_src    = PC_SRC_TRAP;
                o.set_epc   = 1'b1;
                o.set_cause = 1'b1;
                o.mie_clear = 1'b1;
            end
            ST_TRAP_RETURN: begin
                o.pc_src  = PC_SRC_MEPC;
                o.mie_set = 1'b1;
            end
`ifdef MSRV32_WFI_EN
            ST_WAIT: o.pc_src = PC_SRC_NEXT;
`endif
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/msrv32_machine_control_if.sv
// Decoder/interrupt/CSR signals exchanged with the machine-control sequencer.
interface msrv32_machine_control_if;
    logic       illegal_instr_in;
    logic       misaligned_load_in;
    logic       misaligned_store_in;
    logic       misaligned_instr_in;
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs1_addr_in;
    logic [4:0] rs2_addr_in;
    logic [4:0] rd_addr_in;
    logic       e_irq_in;
    logic       s_irq_in;
    logic       t_irq_in;
    logic       mie_in;
    logic       meie_in;
    logic       msie_in;
    logic       mtie_in;

    logic       meip_out;
    logic       trap_taken_out;
    logic       i_or_e_out;
    logic [3:0] cause_out;
    logic       set_epc_out;
    logic       set_cause_out;
    logic       mie_clear_out;
    logic       mie_set_out;
    logic       misaligned_exception_out;
    logic       instret_inc_out;
    logic [1:0] pc_src_out;
    logic       flush_out;

    modport master (
        output illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
               opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
               e_irq_in, s_irq_in, t_irq_in, mie_in, meie_in, msie_in, mtie_in,
        input  meip_out, trap_taken_out, i_or_e_out, cause_out, set_epc_out, set_cause_out,
               mie_clear_out, mie_set_out, misaligned_exception_out, instret_inc_out,
               pc_src_out, flush_out
    );

    modport slave (
        input  illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
               opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
               e_irq_in, s_irq_in, t_irq_in, mie_in, meie_in, msie_in, mtie_in,
        output meip_out, trap_taken_out, i_or_e_out, cause_out, set_epc_out, set_cause_out,
               mie_clear_out, mie_set_out, misaligned_exception_out, instret_inc_out,
               pc_src_out, flush_out
    );
endinterface

// File: rtl/msrv32_sync_ff.sv
// N-stage flop synchroniser for an asynchronous level, synchronous active-low reset.
module msrv32_sync_ff #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[N-2:0], d_i};
    end

    assign q_o = sync_q[N-1];
endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return sequencer for the MSRV32 core.
// Build option MSRV32_WFI_EN adds a WFI sleep state.
//   state          | meaning
//   ST_RESET       | boot: pc_src=boot, flush, no strobes
//   ST_OPERATING   | normal execution, traps/MRET evaluated here
//   ST_TRAP_TAKEN  | one cycle: jump to vector, write mepc/mcause, clear MIE
//   ST_TRAP_RETURN | one cycle: jump to mepc, restore MIE
//   ST_WAIT        | (WFI build) sleeping until an individually enabled irq
module msrv32_machine_control
    import msrv32_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic                           ms_riscv32_mp_clk_in,
    input  logic                           ms_riscv32_mp_rst_in,
    msrv32_machine_control_if.slave        bus
);
    state_e     state_q, state_d;
    ctrl_outs_t outs_q;
    logic [3:0] cause_q, cause_d;
    logic       i_or_e_q, i_or_e_d;
    logic       mis_q, mis_d;
    logic       meip;

    msrv32_sync_ff #(.N(IRQ_SYNC_STAGES)) u_eirq_sync (
        .clk_i  (ms_riscv32_mp_clk_in),
        .rst_ni (ms_riscv32_mp_rst_in),
        .d_i    (bus.e_irq_in),
        .q_o    (meip)
    );

    logic sys_base, ecall, ebreak, mret;
    assign sys_base = (bus.opcode_6_to_2_in == OPC_SYSTEM) && (bus.funct3_in == 3'b000)
                   && (bus.rs1_addr_in == 5'd0) && (bus.rd_addr_in == 5'd0);
    assign ecall  = sys_base && (bus.funct7_in == F7_ECALL) && (bus.rs2_addr_in == RS2_ECALL);
    assign ebreak = sys_base && (bus.funct7_in == F7_ECALL) && (bus.rs2_addr_in == RS2_EBREAK);
    assign mret   = sys_base && (bus.funct7_in == F7_MRET)  && (bus.rs2_addr_in == RS2_MRET);
`ifdef MSRV32_WFI_EN
    logic wfi;
    assign wfi    = sys_base && (bus.funct7_in == F7_WFI)   && (bus.rs2_addr_in == RS2_WFI);
`endif

    logic       exc_any, exc_mis, irq_ready, irq_take, trap;
    logic [3:0] exc_cause, irq_cause;

    always_comb begin
        exc_cause = CAUSE_STORE_MISALIGNED;
        exc_mis   = 1'b1;
        if (bus.illegal_instr_in) begin
            exc_cause = CAUSE_ILLEGAL;
            exc_mis   = 1'b0;
        end else if (bus.misaligned_instr_in) begin
            exc_cause = CAUSE_INSTR_MISALIGNED;
        end else if (ecall) begin
            exc_cause = CAUSE_ECALL_M;
            exc_mis   = 1'b0;
        end else if (ebreak) begin
            exc_cause = CAUSE_BREAKPOINT;
            exc_mis   = 1'b0;
        end else if (bus.misaligned_load_in) begin
            exc_cause = CAUSE_LOAD_MISALIGNED;
        end
    end

    assign exc_any = bus.illegal_instr_in | bus.misaligned_instr_in | ecall | ebreak
                   | bus.misaligned_load_in | bus.misaligned_store_in;

    // Individually enabled sources, before the global MIE gate (WFI wakes on this).
    assign irq_ready = (meip & bus.meie_in) | (bus.s_irq_in & bus.msie_in)
                     | (bus.t_irq_in & bus.mtie_in);
    assign irq_cause = (meip & bus.meie_in)            ? CAUSE_MEI :
                       (bus.s_irq_in & bus.msie_in)    ? CAUSE_MSI : CAUSE_MTI;
    assign irq_take  = bus.mie_in & irq_ready;
    assign trap      = (state_q == ST_OPERATING) & (exc_any | irq_take);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        i_or_e_d = i_or_e_q;
        mis_d    = mis_q;
        case (state_q)
            ST_RESET: state_d = ST_OPERATING;
            ST_OPERATING: begin
                if (exc_any) begin
                    state_d  = ST_TRAP_TAKEN;
                    cause_d  = exc_cause;
                    i_or_e_d = 1'b0;
                    mis_d    = exc_mis;
                end else if (irq_take) begin
                    state_d  = ST_TRAP_TAKEN;
                    cause_d  = irq_cause;
                    i_or_e_d = 1'b1;
                    mis_d    = 1'b0;
                end else if (mret) begin
                    state_d  = ST_TRAP_RETURN;
`ifdef MSRV32_WFI_EN
                end else if (wfi) begin
                    state_d  = ST_WAIT;
`endif
                end
            end
`ifdef MSRV32_WFI_EN
            ST_WAIT: begin
                if (irq_ready) begin
                    if (bus.mie_in) begin
                        state_d  = ST_TRAP_TAKEN;
                        cause_d  = irq_cause;
                        i_or_e_d = 1'b1;
                        mis_d    = 1'b0;
                    end else begin
                        state_d  = ST_OPERATING;
                    end
                end
            end
`endif
            ST_TRAP_TAKEN, ST_TRAP_RETURN: state_d = ST_OPERATING;
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q  <= ST_RESET;
            outs_q   <= state_outs(ST_RESET);
            cause_q  <= 4'd0;
            i_or_e_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            outs_q   <= state_outs(state_d);
            cause_q  <= cause_d;
            i_or_e_q <= i_or_e_d;
            mis_q    <= mis_d;
        end
    end

    assign bus.meip_out                 = meip;
    assign bus.trap_taken_out           = trap;
    assign bus.i_or_e_out               = i_or_e_q;
    assign bus.cause_out                = cause_q;
    assign bus.misaligned_exception_out = mis_q;
    assign bus.pc_src_out               = outs_q.pc_src;
    assign bus.flush_out                = outs_q.flush;
    assign bus.set_epc_out              = outs_q.set_epc;
    assign bus.set_cause_out            = outs_q.set_cause;
    assign bus.mie_clear_out            = outs_q.mie_clear;
    assign bus.mie_set_out              = outs_q.mie_set;
    assign bus.instret_inc_out          = (state_q == ST_OPERATING) && !trap && !mret;
endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed self-checking bench for msrv32_machine_control (WFI checks when MSRV32_WFI_EN is defined).
module tb_msrv32_machine_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    msrv32_machine_control_if bus ();

    msrv32_machine_control #(.IRQ_SYNC_STAGES(2)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .bus                  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.illegal_instr_in    = 0;
        bus.misaligned_load_in  = 0;
        bus.misaligned_store_in = 0;
        bus.misaligned_instr_in = 0;
        bus.opcode_6_to_2_in    = 5'b01100;
        bus.funct3_in           = 0;
        bus.funct7_in           = 0;
        bus.rs1_addr_in         = 0;
        bus.rs2_addr_in         = 0;
        bus.rd_addr_in          = 0;
        bus.s_irq_in            = 0;
        bus.t_irq_in            = 0;
    endtask

    task automatic sys_instr(input logic [6:0] f7, input logic [4:0] rs2);
        bus.opcode_6_to_2_in = 5'b11100;
        bus.funct3_in        = 3'b000;
        bus.rs1_addr_in      = 5'd0;
        bus.rd_addr_in       = 5'd0;
        bus.funct7_in        = f7;
        bus.rs2_addr_in      = rs2;
    endtask

    initial begin
        clear_inputs();
        bus.e_irq_in = 0;
        bus.mie_in   = 0;
        bus.meie_in  = 0;
        bus.msie_in  = 0;
        bus.mtie_in  = 0;

        // reset held for 3 edges
        tick(); tick(); tick();
        chk("rst_pc_src", bus.pc_src_out, 2'b00);
        chk("rst_flush", bus.flush_out, 1);
        chk("rst_set_epc", bus.set_epc_out, 0);
        chk("rst_cause", bus.cause_out, 0);
        chk("rst_i_or_e", bus.i_or_e_out, 0);
        chk("rst_meip", bus.meip_out, 0);
        rst_n = 1;
        #1;
        chk("rel_pc_src", bus.pc_src_out, 2'b00);
        chk("rel_flush", bus.flush_out, 1);
        tick();
        chk("op_pc_src", bus.pc_src_out, 2'b11);
        chk("op_flush", bus.flush_out, 0);
        chk("op_instret", bus.instret_inc_out, 1);

        // illegal beats store-misaligned
        bus.illegal_instr_in = 1; bus.misaligned_store_in = 1;
        #1;
        chk("ill_trap_taken", bus.trap_taken_out, 1);
        chk("ill_instret", bus.instret_inc_out, 0);
        tick(); clear_inputs();
        chk("ill_cause", bus.cause_out, 2);
        chk("ill_i_or_e", bus.i_or_e_out, 0);
        chk("ill_set_epc", bus.set_epc_out, 1);
        chk("ill_set_cause", bus.set_cause_out, 1);
        chk("ill_mie_clear", bus.mie_clear_out, 1);
        chk("ill_pc_src", bus.pc_src_out, 2'b10);
        chk("ill_flush", bus.flush_out, 1);
        chk("ill_mis", bus.misaligned_exception_out, 0);
        tick();
        chk("ill_back_pc_src", bus.pc_src_out, 2'b11);
        chk("ill_back_cause", bus.cause_out, 2);

        // load misaligned
        bus.misaligned_load_in = 1;
        tick(); clear_inputs();
        chk("ldmis_cause", bus.cause_out, 4);
        chk("ldmis_mis", bus.misaligned_exception_out, 1);
        tick();

        // instr-misaligned beats ecall
        bus.misaligned_instr_in = 1; sys_instr(7'd0, 5'd0);
        tick(); clear_inputs();
        chk("imis_cause", bus.cause_out, 0);
        chk("imis_mis", bus.misaligned_exception_out, 1);
        tick();
        sys_instr(7'd0, 5'd0);
        tick(); clear_inputs();
        chk("ecall_cause", bus.cause_out, 11);
        chk("ecall_mis", bus.misaligned_exception_out, 0);
        tick();
        // ebreak beats load misaligned
        sys_instr(7'd0, 5'd1); bus.misaligned_load_in = 1;
        tick(); clear_inputs();
        chk("ebreak_cause", bus.cause_out, 3);
        tick();
        bus.misaligned_store_in = 1;
        tick(); clear_inputs();
        chk("stmis_cause", bus.cause_out, 6);
        tick();

        // external interrupt through synchroniser, gated by MIE
        bus.e_irq_in = 1; bus.meie_in = 1;
        tick();
        chk("meip_lag1", bus.meip_out, 0);
        tick();
        chk("meip_lag2", bus.meip_out, 1);
        chk("eirq_masked", bus.trap_taken_out, 0);
        bus.mie_in = 1;
        #1;
        chk("eirq_trap", bus.trap_taken_out, 1);
        tick();
        bus.e_irq_in = 0; bus.meie_in = 0;
        chk("eirq_cause", bus.cause_out, 11);
        chk("eirq_i_or_e", bus.i_or_e_out, 1);
        tick();
        chk("eirq_done", bus.trap_taken_out, 0);
        // software beats timer
        bus.s_irq_in = 1; bus.t_irq_in = 1; bus.msie_in = 1; bus.mtie_in = 1;
        #1;
        chk("sirq_trap", bus.trap_taken_out, 1);
        tick(); clear_inputs();
        chk("sirq_cause", bus.cause_out, 3);
        chk("sirq_i_or_e", bus.i_or_e_out, 1);
        tick();
        bus.t_irq_in = 1;
        tick(); clear_inputs();
        chk("tirq_cause", bus.cause_out, 7);
        bus.mie_in = 0; bus.msie_in = 0; bus.mtie_in = 0;
        tick();

        // MRET
        sys_instr(7'b0011000, 5'b00010);
        #1;
        chk("mret_instret", bus.instret_inc_out, 0);
        chk("mret_no_trap", bus.trap_taken_out, 0);
        tick(); clear_inputs();
        chk("mret_pc_src", bus.pc_src_out, 2'b01);
        chk("mret_mie_set", bus.mie_set_out, 1);
        chk("mret_flush", bus.flush_out, 1);
        chk("mret_set_epc", bus.set_epc_out, 0);
        chk("mret_cause_hold", bus.cause_out, 7);
        tick();
        chk("mret_back_pc_src", bus.pc_src_out, 2'b11);
        // MRET loses to a simultaneous trap
        sys_instr(7'b0011000, 5'b00010); bus.illegal_instr_in = 1;
        tick(); clear_inputs();
        chk("mret_trap_pc_src", bus.pc_src_out, 2'b10);
        chk("mret_trap_cause", bus.cause_out, 2);

        // reset while in TRAP_TAKEN
        rst_n = 0;
        tick();
        chk("rst_tt_pc_src", bus.pc_src_out, 2'b00);
        chk("rst_tt_set_epc", bus.set_epc_out, 0);
        chk("rst_tt_mie_clear", bus.mie_clear_out, 0);
        chk("rst_tt_cause", bus.cause_out, 0);
        chk("rst_tt_i_or_e", bus.i_or_e_out, 0);
        rst_n = 1;
        tick();
        chk("rst_tt_op", bus.pc_src_out, 2'b11);

        // WFI
        sys_instr(7'b0001000, 5'b00101);
        #1;
        chk("wfi_instret", bus.instret_inc_out, 1);
        tick(); clear_inputs();
`ifdef MSRV32_WFI_EN
        chk("wait_pc_src", bus.pc_src_out, 2'b11);
        chk("wait_flush", bus.flush_out, 1);
        chk("wait_instret", bus.instret_inc_out, 0);
        tick();
        chk("wait_stays", bus.flush_out, 1);
        bus.t_irq_in = 1; bus.mtie_in = 1;
        tick(); clear_inputs(); bus.mtie_in = 0;
        chk("wake_flush", bus.flush_out, 0);
        chk("wake_pc_src", bus.pc_src_out, 2'b11);
        chk("wake_cause", bus.cause_out, 0);
        chk("wake_no_trap", bus.trap_taken_out, 0);
`else
        chk("wfi_nop_flush", bus.flush_out, 0);
        chk("wfi_nop_pc_src", bus.pc_src_out, 2'b11);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
